mfp_avalon_mem_responder: RTL and testbench
===========================================

# mfp_avalon_mem_responder

Avalon-MM slave that answers the bursting `avm_*` master port of `mfp_system` from on-chip block RAM, standing in for the LPDDR2 controller in simulation and on boards without external memory. It accepts single and burst reads and writes with byte enables. It inserts a configurable number of wait states per command and returns read data with a configurable pipelined latency. Exercising these two knobs lets the master's waitrequest and readdatavalid handling be verified without the memory IP.

## Interface
- `MEM_AW`, 12 — log2 of memory depth in 32-bit words; word index = `avm_address[MEM_AW-1:0]`.
- `WAIT_STATES`, 0 — cycles of `avm_waitrequest` high before each command is accepted (0..15).
- `READ_LATENCY`, 2 — cycles from read acceptance to the first `avm_readdatavalid` (1..8).

Ports:
- `clk` in 1 — single clock. One clock; reset is synchronous and active-high.
- `rst` in 1 — synchronous, active-high reset.
- `avm_read` in 1 — read command.
- `avm_write` in 1 — write command / write beat.
- `avm_address` in 27 — word address of the first beat.
- `avm_byteenable` in 4 — per-byte write enable.
- `avm_burstcount` in 3 — beats in the burst; 0 is treated as 1.
- `avm_writedata` in 32 — write beat data.
- `avm_beginbursttransfer`, `avm_begintransfer` in 1 each — accepted and functionally ignored.
- `avm_waitrequest` out 1 — stall; a command or beat transfers only when it is low.
- `avm_readdata` out 32 — read beat data, valid with `avm_readdatavalid`.
- `avm_readdatavalid` out 1 — one pulse per read beat.
- `err` out 1 — sticky protocol-error flag.

## Operation
- States: IDLE, STALL, WBURST, RLAT, RDATA.
- Command present means `avm_read | avm_write`.
- IDLE:
  - `avm_waitrequest` = (`WAIT_STATES` != 0).
  - Command present and `WAIT_STATES`=0: accept in the same cycle.
  - Command present and `WAIT_STATES`>0: go to STALL and load the stall counter.
- STALL:
  - `avm_waitrequest` stays high for `WAIT_STATES` cycles in total, counted from the first command cycle.
  - It then goes low for one cycle, and the command is accepted in that cycle.
  - The master must hold the command stable while stalled.
- Write accept:
  - Beat 1 is written to mem[addr] at the accept edge.
  - Only bytes with `avm_byteenable` set are written.
  - Burstcount n>1: go to WBURST with remaining = n-1 and next address = addr+1.
- WBURST:
  - `avm_waitrequest` is low.
  - Each cycle with `avm_write` high writes one beat and increments the address.
  - Cycles with `avm_write` low are idle beats that transfer nothing.
  - After the last beat, go to IDLE.
- Read accept:
  - Latch addr and n, then go to RLAT.
  - `avm_waitrequest` is high in RLAT and RDATA.
  - The responder does not accept overlapping commands.
- RLAT/RDATA:
  - Beat k (k=0..n-1) presents mem[addr+k] with `avm_readdatavalid` high on consecutive cycles.
  - Beat 0 appears `READ_LATENCY` cycles after the accept edge.
  - After beat n-1, go to IDLE.
- Address arithmetic:
  - The beat address increments modulo 2^`MEM_AW`, so a burst wraps from the top word to 0.
  - Upper address bits above `MEM_AW` are ignored.
- `avm_read` and `avm_write` both high at accept: treat the command as a write and set `err`. `err` clears only on `rst`.
- Memory is synchronous block RAM with no reset; contents survive `rst`.

## Timing
- Reset values:
  - `avm_waitrequest` = 1 while `rst` is high.
  - `avm_readdatavalid` = 0.
  - `avm_readdata` = 0.
  - `err` = 0.
  - State = IDLE.
- From the first cycle after reset, `avm_waitrequest` = (`WAIT_STATES` != 0).
- `rst` mid-burst:
  - Return to IDLE on the next edge.
  - Outstanding read beats are dropped; `avm_readdatavalid` is 0 the following cycle.
  - Any remaining write beats are discarded.
- Write burst of n beats with `WAIT_STATES`=W and no master idles: occupies W+n cycles from the first command cycle.
- Read burst of n beats: accept at edge t; beats on cycles t+L .. t+L+n-1 (L = `READ_LATENCY`).
- A new command can be accepted no earlier than the cycle after the last read beat, plus W stall cycles.
- `avm_readdata` holds its last value when `avm_readdatavalid` is low.

## Test plan
- Single write then single read, W=0, L=2:
  - Stimulus: write 0xDEADBEEF at address 5, byteenable 0xF; then read address 5.
  - Required: `avm_readdatavalid` exactly 2 cycles after the read accept, with `avm_readdata`=0xDEADBEEF.
- Byte enables:
  - Stimulus: write 0x11223344 to address 7; then write 0xAABBCCDD with byteenable 0x5; read back.
  - Required: 0x11BB33DD.
- Bursts with stalls, W=3:
  - Stimulus: 4-beat write 1,2,3,4 at address 0x10, then a 4-beat read.
  - Required: `avm_waitrequest` high 3 cycles before each accept; 4 consecutive valid beats 1,2,3,4; `avm_waitrequest` high throughout the read burst.
- Wrap-around, `MEM_AW`=12:
  - Stimulus: 4-beat write at address 0xFFE with values A,B,C,D.
  - Required: reading 0xFFE, 0xFFF, 0x000, 0x001 returns A,B,C,D.
- Master idle beats and burstcount 0:
  - Stimulus: 3-beat write with `avm_write` low for 2 cycles between beats 1 and 2; then a read with burstcount=0.
  - Required: all 3 words stored; exactly one read beat returned.
- Protocol error and reset:
  - Stimulus: `avm_read` and `avm_write` both high at accept.
  - Required: write performed and `err`=1.
  - Stimulus: assert `rst` on the cycle after a 4-beat read is accepted with L=2.
  - Required: no `avm_readdatavalid` pulses; `err`=0; memory contents intact.

Source files
------------

// File: rtl/mfp_avalon_mem_responder.sv
// rtl/mfp_avalon_mem_responder.sv - Avalon-MM burst slave backed by on-chip block RAM
module mfp_avalon_mem_responder #(
    parameter int MEM_AW       = 12,
    parameter int WAIT_STATES  = 0,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        avm_read,
    input  logic        avm_write,
    input  logic [26:0] avm_address,
    input  logic [3:0]  avm_byteenable,
    input  logic [2:0]  avm_burstcount,
    input  logic [31:0] avm_writedata,
    input  logic        avm_beginbursttransfer,
    input  logic        avm_begintransfer,
    output logic        avm_waitrequest,
    output logic [31:0] avm_readdata,
    output logic        avm_readdatavalid,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, STALL, WBURST, RLAT, RDATA} state_t;

    // Stall counter preload: the IDLE cycle itself is the first stalled cycle.
    localparam logic [3:0] WS_M1  = 4'(WAIT_STATES - 1);
    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    state_t            state;
    state_t            state_next;
    logic [31:0]       mem [0:(1 << MEM_AW) - 1];
    logic [MEM_AW-1:0] cur_addr;
    logic [MEM_AW-1:0] cmd_addr;
    logic [MEM_AW-1:0] mem_addr;
    logic [MEM_AW-1:0] issue_addr;
    logic [2:0]        beats_left;
    logic [2:0]        cmd_beats;
    logic [3:0]        stall_cnt;
    logic [3:0]        lat_cnt;
    logic              cmd;
    logic              accept;
    logic              mem_we;
    logic              issue;
    logic              waitreq_c;
    logic              unused_ok;

    assign cmd       = avm_read | avm_write;
    assign cmd_addr  = avm_address[MEM_AW-1:0];
    assign cmd_beats = (avm_burstcount == 3'd0) ? 3'd1 : avm_burstcount;
    assign unused_ok = &{1'b0, avm_address[26:MEM_AW], avm_beginbursttransfer, avm_begintransfer};

    assign avm_waitrequest = rst | waitreq_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state, stall output, accept and per-beat memory strobes
    always_comb begin
        state_next = state;
        waitreq_c  = 1'b1;
        accept     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = cur_addr;
        issue      = 1'b0;
        issue_addr = cur_addr;
        case (state)
            IDLE: begin
                waitreq_c = (WAIT_STATES != 0);
                if (cmd) begin
                    if (WAIT_STATES == 0) accept = 1'b1;
                    else                  state_next = STALL;
                end
            end
            STALL: begin
                if (!cmd) begin
                    state_next = IDLE;
                end else if (stall_cnt == 4'd0) begin
                    waitreq_c = 1'b0;
                    accept    = 1'b1;
                end
            end
            WBURST: begin
                waitreq_c = 1'b0;
                if (avm_write) begin
                    mem_we = 1'b1;
                    if (beats_left == 3'd1) state_next = IDLE;
                end
            end
            RLAT: begin
                if (lat_cnt == 4'd1) begin
                    issue      = 1'b1;
                    state_next = RDATA;
                end
            end
            RDATA: begin
                // The cycle showing the last beat still stalls; IDLE follows it.
                if (beats_left != 3'd0) issue = 1'b1;
                else                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (accept) begin
            if (avm_write) begin
                mem_we     = 1'b1;
                mem_addr   = cmd_addr;
                state_next = (cmd_beats == 3'd1) ? IDLE : WBURST;
            end else if (READ_LATENCY == 1) begin
                issue      = 1'b1;
                issue_addr = cmd_addr;
                state_next = RDATA;
            end else begin
                state_next = RLAT;
            end
        end
    end

    // Burst address, beat and latency counters plus the sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr   <= '0;
            beats_left <= 3'd0;
            stall_cnt  <= 4'd0;
            lat_cnt    <= 4'd0;
            err        <= 1'b0;
        end else begin
            if (state == IDLE && cmd && WAIT_STATES != 0)
                stall_cnt <= WS_M1;
            else if (state == STALL && stall_cnt != 4'd0)
                stall_cnt <= stall_cnt - 4'd1;

            if (state == RLAT)
                lat_cnt <= lat_cnt - 4'd1;

            if (accept) begin
                if (avm_read && avm_write) err <= 1'b1;
                if (avm_write || READ_LATENCY == 1) begin
                    cur_addr   <= cmd_addr + MEM_AW'(1);
                    beats_left <= cmd_beats - 3'd1;
                end else begin
                    cur_addr   <= cmd_addr;
                    beats_left <= cmd_beats;
                end
                lat_cnt <= LAT_M1;
            end else if (mem_we || issue) begin
                cur_addr   <= cur_addr + MEM_AW'(1);
                beats_left <= beats_left - 3'd1;
            end
        end
    end

    // Block RAM write port with byte lanes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && avm_byteenable[b])
                mem[mem_addr][8*b +: 8] <= avm_writedata[8*b +: 8];
        end
    end

    // Registered read port; data holds between beats
    always_ff @(posedge clk) begin
        if (rst) begin
            avm_readdatavalid <= 1'b0;
            avm_readdata      <= 32'd0;
        end else begin
            avm_readdatavalid <= issue;
            if (issue) avm_readdata <= mem[issue_addr];
        end
    end

endmodule

// File: tb/tb_mfp_avalon_mem_responder.sv
// tb/tb_mfp_avalon_mem_responder.sv - randomized self-checking bench against a word-array memory model
module tb_mfp_avalon_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        rd  [2];
    logic        wr  [2];
    logic        bb  [2];
    logic        bt  [2];
    logic [26:0] ad  [2];
    logic [3:0]  be  [2];
    logic [2:0]  bc  [2];
    logic [31:0] wd  [2];
    logic        wreq[2];
    logic [31:0] rdat[2];
    logic        rdv [2];
    logic        err [2];

    int          total = 0;
    int          bad   = 0;
    logic [31:0] mdl   [2][4096];
    bit          known [2][4096];
    logic [31:0] wbuf  [8];
    logic [31:0] last_rd;

    mfp_avalon_mem_responder #(.MEM_AW(12), .WAIT_STATES(0), .READ_LATENCY(2)) dut0 (
        .clk(clk), .rst(rst[0]), .avm_read(rd[0]), .avm_write(wr[0]), .avm_address(ad[0]),
        .avm_byteenable(be[0]), .avm_burstcount(bc[0]), .avm_writedata(wd[0]),
        .avm_beginbursttransfer(bb[0]), .avm_begintransfer(bt[0]),
        .avm_waitrequest(wreq[0]), .avm_readdata(rdat[0]), .avm_readdatavalid(rdv[0]), .err(err[0]));

    mfp_avalon_mem_responder #(.MEM_AW(12), .WAIT_STATES(3), .READ_LATENCY(3)) dut1 (
        .clk(clk), .rst(rst[1]), .avm_read(rd[1]), .avm_write(wr[1]), .avm_address(ad[1]),
        .avm_byteenable(be[1]), .avm_burstcount(bc[1]), .avm_writedata(wd[1]),
        .avm_beginbursttransfer(bb[1]), .avm_begintransfer(bt[1]),
        .avm_waitrequest(wreq[1]), .avm_readdata(rdat[1]), .avm_readdatavalid(rdv[1]), .err(err[1]));

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_bus(input int d);
        rd[d] = 1'b0; wr[d] = 1'b0; bb[d] = 1'b0; bt[d] = 1'b0;
        ad[d] = 27'd0; be[d] = 4'hF; bc[d] = 3'd1; wd[d] = 32'd0;
    endtask

    task automatic mdl_write(input int d, input int a, input logic [31:0] data, input logic [3:0] ben);
        for (int b = 0; b < 4; b++)
            if (ben[b]) mdl[d][a][8*b +: 8] = data[8*b +: 8];
        if (ben == 4'hF) known[d][a] = 1'b1;
    endtask

    task automatic do_write(input int d, input logic [26:0] a, input logic [2:0] n_bc,
                            input logic [3:0] ben, input int gap, input bit both);
        int n;
        int base;
        int stalls;
        n    = (n_bc == 3'd0) ? 1 : int'(n_bc);
        base = int'(a[11:0]);
        @(negedge clk);
        wr[d] = 1'b1; rd[d] = both; ad[d] = a; bc[d] = n_bc; be[d] = ben; wd[d] = wbuf[0];
        bb[d] = 1'b1; bt[d] = 1'b1;
        stalls = 0;
        #1;
        while (wreq[d] && stalls < 40) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check("wr_stalls", 32'(stalls), 32'(ws(d)));
        if (!wreq[d]) begin
            mdl_write(d, base, wbuf[0], ben);
            for (int k = 1; k < n; k++) begin
                @(negedge clk);
                rd[d] = 1'b0; bb[d] = 1'b0; bt[d] = 1'b0;
                if (k == 1 && gap > 0) begin
                    wr[d] = 1'b0;
                    #1;
                    check("idle_beat_wreq", 32'(wreq[d]), 32'd0);
                    repeat (gap) @(negedge clk);
                end
                wr[d] = 1'b1; wd[d] = wbuf[k];
                #1;
                check("burst_wreq", 32'(wreq[d]), 32'd0);
                mdl_write(d, (base + k) % 4096, wbuf[k], ben);
            end
        end
        @(negedge clk);
        idle_bus(d);
    endtask

    task automatic do_read(input int d, input logic [26:0] a, input logic [2:0] n_bc);
        int n;
        int base;
        int stalls;
        int l;
        bit exp_v;
        bit seen;
        n    = (n_bc == 3'd0) ? 1 : int'(n_bc);
        base = int'(a[11:0]);
        l    = lat(d);
        seen = 1'b0;
        @(negedge clk);
        rd[d] = 1'b1; ad[d] = a; bc[d] = n_bc; bb[d] = 1'b1; bt[d] = 1'b1;
        stalls = 0;
        #1;
        while (wreq[d] && stalls < 40) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check("rd_stalls", 32'(stalls), 32'(ws(d)));
        for (int j = 1; j <= l + n + 1; j++) begin
            @(negedge clk);
            rd[d] = 1'b0; bb[d] = 1'b0; bt[d] = 1'b0;
            #1;
            exp_v = (j >= l && j < l + n);
            check("rdv_timing", 32'(rdv[d]), 32'(exp_v));
            if (rdv[d] && exp_v) begin
                last_rd = rdat[d];
                seen    = 1'b1;
                if (known[d][(base + j - l) % 4096])
                    check("rdata", rdat[d], mdl[d][(base + j - l) % 4096]);
            end
            if (!rdv[d] && j >= l + n && seen)
                check("rdata_hold", rdat[d], last_rd);
            if (j < l + n)
                check("rd_wreq", 32'(wreq[d]), 32'd1);
        end
        idle_bus(d);
    endtask

    initial begin
        logic [26:0] a;
        logic [3:0]  ben;
        logic [2:0]  nb;

        for (int d = 0; d < 2; d++) begin
            idle_bus(d);
            rst[d] = 1'b1;
        end
        last_rd = 32'd0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_wreq", 32'(wreq[d]), 32'd1);
            check("rst_rdv", 32'(rdv[d]), 32'd0);
            check("rst_rdata", rdat[d], 32'd0);
            check("rst_err", 32'(err[d]), 32'd0);
            rst[d] = 1'b0;
        end
        @(negedge clk);
        #1;
        check("idle_wreq_w0", 32'(wreq[0]), 32'd0);
        check("idle_wreq_w3", 32'(wreq[1]), 32'd1);

        // Single write then single read
        wbuf[0] = 32'hDEADBEEF;
        do_write(0, 27'd5, 3'd1, 4'hF, 0, 1'b0);
        do_read(0, 27'd5, 3'd1);
        check("single_rd", last_rd, 32'hDEADBEEF);

        // Byte-enable merge
        wbuf[0] = 32'h11223344;
        do_write(0, 27'd7, 3'd1, 4'hF, 0, 1'b0);
        wbuf[0] = 32'hAABBCCDD;
        do_write(0, 27'd7, 3'd1, 4'h5, 0, 1'b0);
        do_read(0, 27'd7, 3'd1);
        check("be_merge", last_rd, 32'h11BB33DD);

        // Wrap from the top word, upper address bits set
        wbuf[0] = 32'hA0A0A0A0; wbuf[1] = 32'hB1B1B1B1; wbuf[2] = 32'hC2C2C2C2; wbuf[3] = 32'hD3D3D3D3;
        do_write(0, {15'h1234, 12'hFFE}, 3'd4, 4'hF, 0, 1'b0);
        do_read(0, 27'hFFE, 3'd1);
        check("wrap_ffe", last_rd, 32'hA0A0A0A0);
        do_read(0, 27'hFFF, 3'd1);
        check("wrap_fff", last_rd, 32'hB1B1B1B1);
        do_read(0, 27'h000, 3'd1);
        check("wrap_000", last_rd, 32'hC2C2C2C2);
        do_read(0, 27'h001, 3'd1);
        check("wrap_001", last_rd, 32'hD3D3D3D3);
        do_read(0, {15'h7FFF, 12'hFFE}, 3'd4);
        check("wrap_burst_last", last_rd, 32'hD3D3D3D3);

        // Master idle beats, then burstcount 0
        wbuf[0] = 32'h00000111; wbuf[1] = 32'h00000222; wbuf[2] = 32'h00000333;
        do_write(0, 27'h40, 3'd3, 4'hF, 2, 1'b0);
        do_read(0, 27'h40, 3'd0);
        check("bc0_rd", last_rd, 32'h00000111);
        do_read(0, 27'h42, 3'd1);
        check("gap_beat3", last_rd, 32'h00000333);

        // Read and write together: performed as a write and flagged
        wbuf[0] = 32'h5A5A5A5A;
        do_write(0, 27'h50, 3'd1, 4'hF, 0, 1'b1);
        #1;
        check("err_set", 32'(err[0]), 32'd1);
        do_read(0, 27'h50, 3'd1);
        check("both_write", last_rd, 32'h5A5A5A5A);

        // Reset the cycle after a 4-beat read is accepted
        @(negedge clk);
        rd[0] = 1'b1; ad[0] = 27'h40; bc[0] = 3'd4;
        #1;
        check("rst_test_accept", 32'(wreq[0]), 32'd0);
        @(negedge clk);
        rd[0] = 1'b0; rst[0] = 1'b1;
        #1;
        check("rst_mid_wreq", 32'(wreq[0]), 32'd1);
        check("rst_mid_rdv", 32'(rdv[0]), 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            #1;
            check("rst_no_rdv", 32'(rdv[0]), 32'd0);
            @(negedge clk);
        end
        check("rst_err_clear", 32'(err[0]), 32'd0);
        do_read(0, 27'h40, 3'd3);
        check("mem_survives", last_rd, 32'h00000333);

        // Stalled bursts
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
        do_write(1, 27'h10, 3'd4, 4'hF, 0, 1'b0);
        do_read(1, 27'h10, 3'd4);
        check("stall_burst_last", last_rd, 32'd4);
        do_read(1, 27'h13, 3'd1);
        check("stall_beat4", last_rd, 32'd4);

        // Randomized traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 30; i++) begin
                a = 27'($urandom);
                a[11:0] = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 31))
                                                      : 12'($urandom_range(4088, 4095));
                nb = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) begin
                    for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
                    ben = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                    do_write(d, a, nb, ben, $urandom_range(0, 2), 1'b0);
                end else begin
                    do_read(d, a, nb);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
